// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchronizer, mid-bit sampling FSM and a
// one-entry output buffer with valid/ready handshake, frame error and overrun.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr,
    output logic       busy
);

    localparam int unsigned CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] START_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          s_meta;
    logic          s_sync;

    // Line synchronizer; resets to the idle (high) level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_meta <= 1'b1;
            s_sync <= 1'b1;
        end else begin
            s_meta <= s_in;
            s_sync <= s_meta;
        end
    end

    // Deframing FSM plus output buffer; later assignments in the STOP branch
    // override the handshake/clear defaults so delivery and overrun-set win.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            busy      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (err_clr) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!s_sync) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == START_LAST) begin
                        cnt <= '0;
                        if (s_sync) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                            idx   <= '0;
                        end
                    end else begin
                        cnt <= CW'(cnt + 1'b1);
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {s_sync, shreg[7:1]};
                        idx   <= 3'(idx + 1'b1);
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= CW'(cnt + 1'b1);
                    end
                end

                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (s_sync) begin
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= CW'(cnt + 1'b1);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks/bit: directed scenarios plus
// randomized back-to-back frames checked against an event-level model.
module tb_uart_rx;

    localparam int unsigned CPB = 16;
    localparam int LAT = 154;   // E0 to stop-bit sample edge
    localparam int FRAME = 160; // 10 bits * CPB

    logic       clk = 1'b0;
    logic       rst;
    logic       s_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       err_clr;
    logic       busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_in      (s_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_clr   (err_clr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] d;
    } ev_t;

    ev_t  rq[$];       // rx_valid rising events
    int   fq[$];       // cycles with frame_err high
    int   vcnt = 0;    // cycles with rx_valid high
    int   bcnt = 0;    // cycles with busy high
    logic prev_valid = 1'b0;

    // Observe outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rx_valid && !prev_valid) begin
            ev_t e;
            e.cyc = cyc;
            e.d   = rx_data;
            rq.push_back(e);
        end
        if (rx_valid) vcnt++;
        if (frame_err) fq.push_back(cyc);
        if (busy) bcnt++;
        prev_valid = rx_valid;
    end

    int ntests = 0;
    int nfail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        rq.delete();
        fq.delete();
        vcnt = 0;
        bcnt = 0;
    endtask

    // Advance n edges; always returns 1 time unit after an active edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame starting now; e0 is the first edge seeing the start bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, output int e0);
        logic [9:0] bits;
        bits = {stop_ok, b, 1'b0};
        e0 = cyc + 1;
        for (int k = 0; k < 10; k++) begin
            s_in = bits[k];
            repeat (CPB) @(posedge clk);
            #1;
        end
        s_in = 1'b1;
    endtask

    function automatic int first_cyc();
        return (rq.size() > 0) ? rq[0].cyc : -1;
    endfunction

    function automatic logic [7:0] first_dat();
        return (rq.size() > 0) ? rq[0].d : 8'hxx;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   e0a, e0b, e0c, gap;
        ev_t  exp_v[$];
        int   exp_f[$];
        logic [7:0] rb;
        logic       ok;

        rst = 1'b0; s_in = 1'b1; rx_ready = 1'b0; err_clr = 1'b0;
        idle(3);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b1;
        idle(20);

        // 1: single frame, consumer not ready, then one-cycle ready pulse
        clear_mon();
        send_frame(8'hA5, 1'b1, e0a);
        check("s1_rises", 32'(rq.size()), 1);
        check("s1_rise_cyc", 32'(first_cyc()), 32'(e0a + LAT));
        check("s1_data", 32'(first_dat()), 32'hA5);
        check("s1_busy_after", 32'(busy), 0);
        idle(100);
        check("s1_hold_valid", 32'(rx_valid), 1);
        check("s1_hold_data", 32'(rx_data), 32'hA5);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        check("s1_consumed", 32'(rx_valid), 0);

        // 2: three-cycle glitch
        clear_mon();
        s_in = 1'b0;
        idle(3);
        s_in = 1'b1;
        idle(30);
        check("s2_busy_pulsed", 32'(bcnt != 0), 1);
        check("s2_busy_end", 32'(busy), 0);
        check("s2_no_valid", 32'(rq.size()), 0);
        check("s2_no_ferr", 32'(fq.size()), 0);
        check("s2_data_kept", 32'(rx_data), 32'hA5);

        // 3: bad stop bit, then a good frame
        clear_mon();
        send_frame(8'h3C, 1'b0, e0a);
        idle(16);
        send_frame(8'h7E, 1'b1, e0b);
        check("s3_ferr_cycles", 32'(fq.size()), 1);
        check("s3_ferr_cyc", 32'((fq.size() > 0) ? fq[0] : -1), 32'(e0a + LAT));
        check("s3_rises", 32'(rq.size()), 1);
        check("s3_rise_cyc", 32'(first_cyc()), 32'(e0b + LAT));
        check("s3_data", 32'(first_dat()), 32'h7E);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;

        // 4: back-to-back with consumer stalled -> overrun
        clear_mon();
        send_frame(8'h11, 1'b1, e0a);
        send_frame(8'h22, 1'b1, e0b);
        check("s4_data", 32'(rx_data), 32'h11);
        check("s4_overrun", 32'(overrun), 1);
        check("s4_valid", 32'(rx_valid), 1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("s4_ovr_clr", 32'(overrun), 0);
        check("s4_valid_kept", 32'(rx_valid), 1);
        check("s4_data_kept", 32'(rx_data), 32'h11);
        rx_ready = 1'b1;
        idle(1);
        check("s4_consumed", 32'(rx_valid), 0);

        // 5: zero-wait consumer, back-to-back 0x00 / 0xFF
        clear_mon();
        send_frame(8'h00, 1'b1, e0a);
        send_frame(8'hFF, 1'b1, e0b);
        idle(2);
        check("s5_pulses", 32'(rq.size()), 2);
        check("s5_valid_cycles", 32'(vcnt), 2);
        check("s5_cyc0", 32'(first_cyc()), 32'(e0a + LAT));
        check("s5_dat0", 32'(first_dat()), 32'h00);
        check("s5_spacing", 32'((rq.size() > 1) ? rq[1].cyc - rq[0].cyc : -1), 32'(FRAME));
        check("s5_dat1", 32'((rq.size() > 1) ? rq[1].d : 8'hxx), 32'hFF);
        check("s5_overrun", 32'(overrun), 0);

        // Random: back-to-back/gapped frames, zero-wait consumer, some bad stops
        clear_mon();
        for (int n = 0; n < 12; n++) begin
            rb = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send_frame(rb, ok, e0a);
            if (ok) begin
                ev_t e;
                e.cyc = e0a + LAT;
                e.d   = rb;
                exp_v.push_back(e);
                gap = int'($urandom_range(0, 6));
            end else begin
                exp_f.push_back(e0a + LAT);
                gap = int'($urandom_range(4, 10));
            end
            if (gap > 0) idle(gap);
        end
        idle(4);
        check("rnd_valid_count", 32'(rq.size()), 32'(exp_v.size()));
        check("rnd_valid_cycles", 32'(vcnt), 32'(exp_v.size()));
        check("rnd_ferr_count", 32'(fq.size()), 32'(exp_f.size()));
        for (int i = 0; i < exp_v.size() && i < rq.size(); i++) begin
            check("rnd_valid_cyc", 32'(rq[i].cyc), 32'(exp_v[i].cyc));
            check("rnd_valid_data", 32'(rq[i].d), 32'(exp_v[i].d));
        end
        for (int i = 0; i < exp_f.size() && i < fq.size(); i++) begin
            check("rnd_ferr_cyc", 32'(fq[i]), 32'(exp_f[i]));
        end
        check("rnd_overrun", 32'(overrun), 0);

        // 6: reset during data bit 4 with a full buffer and sticky overrun
        rx_ready = 1'b0;
        send_frame(8'h99, 1'b1, e0a);
        send_frame(8'h44, 1'b1, e0b);
        check("s6_pre_overrun", 32'(overrun), 1);
        e0c = cyc + 1;
        fork
            send_frame(8'hC3, 1'b1, e0a);
            begin
                idle(86);
                check("s6_pre_busy", 32'(busy), 1);
                rst = 1'b0;
                #1;
                check("s6_rst_data", 32'(rx_data), 32'h00);
                check("s6_rst_valid", 32'(rx_valid), 0);
                check("s6_rst_ferr", 32'(frame_err), 0);
                check("s6_rst_overrun", 32'(overrun), 0);
                check("s6_rst_busy", 32'(busy), 0);
                idle(2);
                rst = 1'b1;
            end
        join
        check("s6_frame_e0", 32'(e0a), 32'(e0c));
        idle(FRAME);
        clear_mon();
        rx_ready = 1'b1;
        send_frame(8'h5A, 1'b1, e0a);
        idle(2);
        check("s6_rises", 32'(rq.size()), 1);
        check("s6_rise_cyc", 32'(first_cyc()), 32'(e0a + LAT));
        check("s6_data", 32'(first_dat()), 32'h5A);
        check("s6_no_ferr", 32'(fq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
